// File: rtl/led_pwm.sv
// led_pwm: eight-channel MMIO LED PWM controller with shadowed duty registers.
//   clk, rst         : clock, synchronous active-high reset
//   cs, we           : chip select, write enable (one access per cycle)
//   address          : word address
//   write_data       : write data
//   read_data        : combinational read data, 0 when cs is low
//   ready            : equals cs, every access completes in one cycle
//   led              : registered PWM outputs
module led_pwm #(
    parameter logic [15:0] PRESCALE_RESET = 16'd97
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [7:0]  led
);
    logic        enable_q, enable_d;
    logic        invert_q, invert_d;
    logic [15:0] prescale_q, prescale_d;
    logic        wrap_q, wrap_d;
    logic [15:0] pre_ctr_q, pre_ctr_d;
    logic [7:0]  pwm_ctr_q, pwm_ctr_d;
    logic [7:0]  led_q, led_d;
    logic [7:0]  shadow_q [8];
    logic [7:0]  shadow_d [8];
    logic [7:0]  active_q [8];
    logic [7:0]  active_d [8];
    logic        wr, tick, boundary;

    assign wr       = cs & we;
    // >= rather than == so a shrinking prescale never strands pre_ctr above it
    assign tick     = enable_q && (pre_ctr_q >= prescale_q);
    assign boundary = tick && (pwm_ctr_q == 8'hff);
    assign ready    = cs;
    assign led      = led_q;

    always_comb begin
        enable_d   = (wr && address == 8'h08) ? write_data[0] : enable_q;
        invert_d   = (wr && address == 8'h08) ? write_data[1] : invert_q;
        prescale_d = (wr && address == 8'h09) ? write_data[15:0] : prescale_q;
        // a boundary in the same cycle as a clearing write keeps wrap set
        wrap_d     = boundary ? 1'b1 : (wr && address == 8'h0a) ? 1'b0 : wrap_q;
        pre_ctr_d  = (!enable_q || tick) ? 16'd0 : pre_ctr_q + 16'd1;
        pwm_ctr_d  = !enable_q ? 8'd0 : pwm_ctr_q + {7'd0, tick};
        for (int i = 0; i < 8; i++) begin
            shadow_d[i] = (wr && address[7:3] == 5'h02 && address[2:0] == 3'(i)) ? write_data[7:0] : shadow_q[i];
            // loads from the pre-write shadow, so a colliding write waits a period
            active_d[i] = (!enable_q || boundary) ? shadow_q[i] : active_q[i];
            led_d[i]    = enable_q & ((pwm_ctr_q < active_q[i]) ^ invert_q);
        end
    end

    always_comb begin
        read_data = 32'd0;
        if (cs) begin
            case (address)
                8'h00:   read_data = 32'h6c656470;
                8'h01:   read_data = 32'h776d2020;
                8'h02:   read_data = 32'h302e3130;
                8'h08:   read_data = {30'd0, invert_q, enable_q};
                8'h09:   read_data = {16'd0, prescale_q};
                8'h0a:   read_data = {31'd0, wrap_q};
                default: read_data = (address[7:3] == 5'h02) ? {24'd0, shadow_q[address[2:0]]} : 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q   <= 1'b0;
            invert_q   <= 1'b0;
            prescale_q <= PRESCALE_RESET;
            wrap_q     <= 1'b0;
            pre_ctr_q  <= 16'd0;
            pwm_ctr_q  <= 8'd0;
            led_q      <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 8'd0;
                active_q[i] <= 8'd0;
            end
        end else begin
            enable_q   <= enable_d;
            invert_q   <= invert_d;
            prescale_q <= prescale_d;
            wrap_q     <= wrap_d;
            pre_ctr_q  <= pre_ctr_d;
            pwm_ctr_q  <= pwm_ctr_d;
            led_q      <= led_d;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end
endmodule

// File: tb/tb_led_pwm.sv
// tb_led_pwm: directed table-driven bench for led_pwm.
module tb_led_pwm;
    logic        clk, rst, cs, we, ready;
    logic [7:0]  address, led;
    logic [31:0] write_data, read_data;
    int          n_cmp, n_err;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [22];

    led_pwm dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", n, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cs = 1'b0;
        we = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1;
        we = 1'b1;
        address = a;
        write_data = d;
        @(posedge clk);
        #1 cs = 1'b0;
        we = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        cs = 1'b1;
        we = 1'b0;
        address = a;
        #1;
        check(n, read_data, exp);
        check({n, "_ready"}, {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1 cs = 1'b0;
    endtask

    initial begin
        int h [4];
        int bad;
        n_cmp = 0;
        n_err = 0;
        cs = 1'b0;
        we = 1'b0;
        rst = 1'b1;
        address = 8'd0;
        write_data = 32'd0;
        tbl[0]  = '{1'b0, 8'h00, 32'h0, 32'h6c656470};
        tbl[1]  = '{1'b0, 8'h01, 32'h0, 32'h776d2020};
        tbl[2]  = '{1'b0, 8'h02, 32'h0, 32'h302e3130};
        tbl[3]  = '{1'b0, 8'h08, 32'h0, 32'h0};
        tbl[4]  = '{1'b0, 8'h09, 32'h0, 32'd97};
        tbl[5]  = '{1'b0, 8'h0a, 32'h0, 32'h0};
        tbl[6]  = '{1'b0, 8'h10, 32'h0, 32'h0};
        tbl[7]  = '{1'b0, 8'h17, 32'h0, 32'h0};
        tbl[8]  = '{1'b0, 8'h03, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 8'hff, 32'h0, 32'h0};
        tbl[10] = '{1'b1, 8'h09, 32'hffff1234, 32'h0};
        tbl[11] = '{1'b0, 8'h09, 32'h0, 32'h1234};
        tbl[12] = '{1'b1, 8'h10, 32'hffffffab, 32'h0};
        tbl[13] = '{1'b0, 8'h10, 32'h0, 32'hab};
        tbl[14] = '{1'b1, 8'h00, 32'h0, 32'h0};
        tbl[15] = '{1'b0, 8'h00, 32'h0, 32'h6c656470};
        tbl[16] = '{1'b1, 8'h05, 32'hffffffff, 32'h0};
        tbl[17] = '{1'b0, 8'h05, 32'h0, 32'h0};
        tbl[18] = '{1'b1, 8'h17, 32'h155, 32'h0};
        tbl[19] = '{1'b0, 8'h17, 32'h0, 32'h55};
        tbl[20] = '{1'b1, 8'h08, 32'hfffffffc, 32'h0};
        tbl[21] = '{1'b0, 8'h08, 32'h0, 32'h0};

        do_reset();
        #1;
        check("idle_read_data", read_data, 32'd0);
        check("idle_ready", {31'd0, ready}, 32'd0);
        check("reset_led", {24'd0, led}, 32'd0);
        for (int i = 0; i < 22; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].data);
            else rd_chk($sformatf("reg_%0d_a%02h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
        end
        do_reset();
        rd_chk("rst_prescale", 8'h09, 32'd97);
        rd_chk("rst_duty0", 8'h10, 32'd0);
        rd_chk("rst_duty7", 8'h17, 32'd0);

        // duty ratio
        do_reset();
        wr(8'h09, 32'd0);
        wr(8'h10, 32'd64);
        wr(8'h11, 32'd255);
        wr(8'h12, 32'd0);
        wr(8'h08, 32'd1);
        h = '{0, 0, 0, 0};
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            h[0] += int'(led[0]);
            h[1] += int'(led[1]);
            h[2] += int'(led[2]);
        end
        check("ratio_led0", h[0], 32'd64);
        check("ratio_led1", h[1], 32'd255);
        check("ratio_led2", h[2], 32'd0);
        rd_chk("ratio_wrap", 8'h0a, 32'd1);

        // shadow update mid-period, and a duty write colliding with a boundary
        do_reset();
        wr(8'h09, 32'd0);
        wr(8'h10, 32'd32);
        wr(8'h08, 32'd1);
        h = '{0, 0, 0, 0};
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (k == 11 || k == 512) begin
                cs = 1'b1;
                we = 1'b1;
                address = 8'h10;
                write_data = (k == 11) ? 32'd200 : 32'd100;
            end
            @(posedge clk);
            #1 cs = 1'b0;
            we = 1'b0;
            h[(k - 1) / 256] += int'(led[0]);
        end
        check("shadow_p1", h[0], 32'd32);
        check("shadow_p2", h[1], 32'd200);
        check("shadow_collide_p3", h[2], 32'd200);
        check("shadow_p4", h[3], 32'd100);

        // invert and disable
        do_reset();
        wr(8'h13, 32'd0);
        wr(8'h08, 32'd3);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1 bad += int'(led !== 8'hff);
        end
        check("invert_on_cycles_bad", bad, 32'd0);
        wr(8'h08, 32'd2);
        @(posedge clk);
        #1 check("disable_led", {24'd0, led}, 32'd0);
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1 bad += int'(led !== 8'h00);
        end
        check("disable_hold_bad", bad, 32'd0);
        wr(8'h09, 32'd0);
        wr(8'h10, 32'd1);
        wr(8'h08, 32'd1);
        @(posedge clk);
        #1 check("reenable_pwm0", {24'd0, led}, 32'h01);
        @(posedge clk);
        #1 check("reenable_pwm1", {24'd0, led}, 32'h00);

        // prescale shrink below current pre_ctr
        do_reset();
        wr(8'h10, 32'd1);
        wr(8'h11, 32'd2);
        wr(8'h12, 32'd3);
        wr(8'h09, 32'd1000);
        wr(8'h08, 32'd1);
        repeat (600) @(posedge clk);
        #1 check("shrink_pre", {29'd0, led[2:0]}, 32'd7);
        wr(8'h09, 32'd5);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1 check($sformatf("shrink_k%0d", k), {29'd0, led[2:0]},
                     (k == 1) ? 32'd7 : (k <= 7) ? 32'd6 : (k <= 13) ? 32'd4 : 32'd0);
        end

        // wrap set/clear collision
        do_reset();
        wr(8'h09, 32'd0);
        wr(8'h08, 32'd1);
        repeat (255) @(posedge clk);
        wr(8'h0a, 32'd0);
        rd_chk("wrap_collide", 8'h0a, 32'd1);
        wr(8'h0a, 32'd0);
        rd_chk("wrap_cleared", 8'h0a, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
